// File: rtl/mem_ctrl.sv
// Byte-serial RAM controller arbitrating instruction fetches and load/store
// accesses onto a single 8-bit synchronous-read RAM port.
module mem_ctrl #(
    parameter int ADDR_W = 17
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    input  logic              if_flush,
    output logic              if_ack,
    output logic [31:0]       if_inst,
    input  logic              mem_req,
    input  logic              mem_we,
    input  logic [2:0]        mem_op,
    input  logic [ADDR_W-1:0] mem_addr,
    input  logic [31:0]       mem_wdata,
    output logic              mem_ack,
    output logic [31:0]       mem_rdata,
    output logic [ADDR_W-1:0] ram_a,
    output logic [7:0]        ram_dout,
    output logic              ram_wr,
    input  logic [7:0]        ram_din
);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t              state_q, state_d;
    logic [2:0]          c_q, c_d;
    logic                own_mem_q, own_mem_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [1:0]          size_q, size_d;
    logic                uns_q, uns_d;
    logic                we_q, we_d;
    logic [31:0]         wdata_q, wdata_d;
    logic [31:0]         data_q, data_d;
    logic [31:0]         inst_q, inst_d;
    logic [31:0]         rdata_q, rdata_d;
    logic [2:0]          n_len;
    logic [1:0]          cap_idx;

    function automatic logic [31:0] extend(input logic [31:0] d, input logic [1:0] sz,
                                           input logic uns);
        logic [31:0] r;
        case (sz)
            2'b00:   r = {{24{d[7]  & ~uns}}, d[7:0]};
            2'b01:   r = {{16{d[15] & ~uns}}, d[15:0]};
            default: r = d;
        endcase
        return r;
    endfunction

    assign n_len   = (size_q == 2'b00) ? 3'd1 : (size_q == 2'b01) ? 3'd2 : 3'd4;
    // Read data lags the address by one cycle, so count c lands in byte c-1.
    assign cap_idx = c_q[1:0] - 2'd1;

    always_comb begin
        state_d   = state_q;
        c_d       = c_q;
        own_mem_d = own_mem_q;
        addr_d    = addr_q;
        size_d    = size_q;
        uns_d     = uns_q;
        we_d      = we_q;
        wdata_d   = wdata_q;
        data_d    = data_q;
        inst_d    = inst_q;
        rdata_d   = rdata_q;
        ram_a     = '0;
        ram_dout  = '0;
        ram_wr    = 1'b0;
        if_ack    = 1'b0;
        mem_ack   = 1'b0;
        if_inst   = inst_q;
        mem_rdata = rdata_q;
        case (state_q)
            IDLE: begin
                if (mem_req) begin
                    own_mem_d = 1'b1;
                    addr_d    = mem_addr;
                    size_d    = mem_op[1:0];
                    uns_d     = mem_op[2];
                    we_d      = mem_we;
                    wdata_d   = mem_wdata;
                    data_d    = '0;
                    c_d       = '0;
                    state_d   = BUSY;
                end else if (if_req && !if_flush) begin
                    own_mem_d = 1'b0;
                    addr_d    = if_addr;
                    size_d    = 2'b10;
                    uns_d     = 1'b0;
                    we_d      = 1'b0;
                    wdata_d   = '0;
                    data_d    = '0;
                    c_d       = '0;
                    state_d   = BUSY;
                end
            end
            BUSY: begin
                if (!own_mem_q && if_flush) begin
                    c_d     = '0;
                    state_d = IDLE;
                end else begin
                    if (c_q < n_len) begin
                        ram_a = addr_q + ADDR_W'(c_q);
                        if (we_q) begin
                            ram_wr   = 1'b1;
                            ram_dout = wdata_q[{c_q[1:0], 3'b000} +: 8];
                        end
                    end
                    if (!we_q && c_q != 3'd0)
                        data_d[{cap_idx, 3'b000} +: 8] = ram_din;
                    c_d = c_q + 3'd1;
                    if (c_q == n_len) begin
                        state_d = DONE;
                        if (own_mem_q && !we_q)
                            rdata_d = extend(data_d, size_q, uns_q);
                    end
                end
            end
            DONE: begin
                c_d     = '0;
                state_d = IDLE;
                if (own_mem_q) begin
                    mem_ack = 1'b1;
                end else if (!if_flush) begin
                    // A late flush suppresses both the pulse and the visible word.
                    if_ack  = 1'b1;
                    if_inst = data_q;
                    inst_d  = data_q;
                end
            end
            default: begin
                c_d     = '0;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            c_q       <= '0;
            own_mem_q <= 1'b0;
            addr_q    <= '0;
            size_q    <= '0;
            uns_q     <= 1'b0;
            we_q      <= 1'b0;
            wdata_q   <= '0;
            data_q    <= '0;
            inst_q    <= '0;
            rdata_q   <= '0;
        end else begin
            state_q   <= state_d;
            c_q       <= c_d;
            own_mem_q <= own_mem_d;
            addr_q    <= addr_d;
            size_q    <= size_d;
            uns_q     <= uns_d;
            we_q      <= we_d;
            wdata_q   <= wdata_d;
            data_q    <= data_d;
            inst_q    <= inst_d;
            rdata_q   <= rdata_d;
        end
    end

endmodule

// File: doc/mem_ctrl.md
MEM_CTRL -- requirements
Module: mem_ctrl

Interface
REQ-001 SHALL have parameter ADDR_W, default 17, meaning RAM byte-address width.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on the rising edge.
REQ-003 SHALL have port rst  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port if_req  input  1  fetch request; held until if_ack.
REQ-005 SHALL have port if_addr  input  ADDR_W  fetch byte address.
REQ-006 SHALL have port if_flush  input  1  branch taken in execute; cancels a pending or in-flight fetch.
REQ-007 SHALL have port if_ack  output  1  one-cycle pulse; if_inst valid.
REQ-008 SHALL have port if_inst  output  32  fetched word, little-endian.
REQ-009 SHALL have port mem_req  input  1  load/store request; held until mem_ack.
REQ-010 SHALL have port mem_we  input  1  1 = store, 0 = load.
REQ-011 SHALL have port mem_op  input  3  [1:0] size (00 byte, 01 half, 10 word; 11 treated as word); [2] unsigned load.
REQ-012 SHALL have port mem_addr  input  ADDR_W  load/store byte address.
REQ-013 SHALL have port mem_wdata  input  32  store data; low bytes used.
REQ-014 SHALL have port mem_ack  output  1  one-cycle pulse; load data valid or store complete.
REQ-015 SHALL have port mem_rdata  output  32  extended load data.
REQ-016 SHALL have port ram_a  output  ADDR_W  RAM byte address.
REQ-017 SHALL have port ram_dout  output  8  RAM write byte.
REQ-018 SHALL have port ram_wr  output  1  1 = write this cycle.
REQ-019 SHALL have port ram_din  input  8  RAM read byte; valid the cycle after ram_a is presented.

Function
REQ-020 SHALL implement the states IDLE, BUSY and DONE, plus a 3-bit byte counter c and a latched owner (IF or MEM).
REQ-021 In IDLE, with any request present, SHALL latch address, size, sign, we and wdata, set c=0 and go to BUSY; mem_req wins over if_req.
REQ-022 SHALL NOT accept if_req in a cycle where if_flush=1.
REQ-023 N, the transfer length, SHALL be 1, 2 or 4 bytes; IF transfers are always 4 bytes.
REQ-024 In BUSY, for c<N, SHALL drive ram_a = latched address + c, computed modulo 2^ADDR_W (wraps; no alignment check).
REQ-025 In BUSY, for stores with c<N, SHALL drive ram_wr=1 and ram_dout = wdata byte c.
REQ-026 In BUSY, for c≥1 on reads, SHALL capture ram_din into byte c-1 of the data register.
REQ-027 SHALL increment c each BUSY cycle; at c=N it SHALL drive no access and go to DONE.
REQ-028 In DONE, SHALL pulse the owner's ack for exactly one cycle, then return to IDLE.
REQ-029 Latency: request accepted at edge T; ack high in cycle T+N+2 (word 6 cycles, half 4, byte 3); back-to-back spacing is N+3 cycles.
REQ-030 Loads: byte/half SHALL sign-extend when mem_op[2]=0 and zero-extend when mem_op[2]=1.
REQ-031 if_inst and mem_rdata SHALL hold their last values between acks.
REQ-032 if_flush during IF BUSY or DONE SHALL abort: ram idle, no if_ack, IDLE next cycle.
REQ-033 if_flush SHALL have no effect on a MEM transaction; stores are never aborted.
REQ-034 Outside BUSY with c<N, SHALL hold ram_wr=0 and ram_a=0.
REQ-035 Dropping a request before its ack is a protocol violation; the latched transaction SHALL complete regardless.

Reset
REQ-036 rst=0 SHALL immediately force state IDLE, c=0, and all outputs to 0 (including if_inst and mem_rdata).
REQ-037 Reset mid-store SHALL stop writing at once; bytes already written stay written; no ack is issued.

Verification
REQ-038 LW at 0x00100 with RAM 11,22,33,44: mem_ack in cycle T+6, mem_rdata=0x44332211.
REQ-039 LB at 0x00005 (RAM 0x80): mem_rdata=0xFFFFFF80; same access as LBU: 0x00000080; ack at T+3.
REQ-040 SH 0x0000BEEF at 0x1FFFF: writes EF at 0x1FFFF and BE at 0x00000; ack at T+4.
REQ-041 if_req and mem_req together in IDLE: MEM served first; IF ack follows 3+N_mem+... i.e. IF accepted in the IDLE cycle after mem_ack; if_inst correct.
REQ-042 if_flush in BUSY cycle c=2 of a fetch: no if_ack, ram_wr stays 0, new if_req accepted the cycle after IDLE.
REQ-043 rst low during SW c=2: ram_wr drops asynchronously, only 2 bytes written, no mem_ack, all outputs 0.
